// File: rtl/ram_arbiter.sv
// Single-port RAM arbiter: the CPU owns the RAM by default. A host request takes
// a single cycle, either when the CPU is idle or after at most MAXWAIT contended cycles.
module ram_arbiter #(
  parameter int N       = 6,
  parameter int W       = 16,
  parameter int MAXWAIT = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  // Handshake: the CPU holds cpu_req (and its address/data) for every cycle that
  // cpu_stall is high. The host holds host_req level-high until it sees host_gnt.
  // The access completes in the host_gnt cycle, and host_req still high in the
  // following cycle counts as a new request.
  input  logic         cpu_req,
  input  logic         cpu_we,
  input  logic [N-1:0] cpu_ad,
  input  logic [W-1:0] cpu_din,
  output logic [W-1:0] cpu_dout,
  output logic         cpu_stall,
  input  logic         host_req,
  input  logic         host_we,
  input  logic [N-1:0] host_ad,
  input  logic [W-1:0] host_din,
  output logic         host_gnt,
  output logic [W-1:0] host_dout,
  output logic         host_valid,
  output logic [N-1:0] ram_ad,
  output logic [W-1:0] ram_din,
  output logic         ram_en,
  input  logic [W-1:0] ram_dout,
  output logic [1:0]   dbg_state
);

  localparam int CW = $clog2(MAXWAIT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOST = 2'd2
  } state_t;

  state_t        state, next_state;
  logic [CW-1:0] cnt, next_cnt;
  logic          host_owns;

  assign host_owns = (state == HOST);
  assign dbg_state = state;
  assign cpu_dout  = ram_dout;

  // Datapath mux and strobes; reset forces every strobe low, whatever the state.
  always_comb begin
    ram_ad    = cpu_ad;
    ram_din   = cpu_din;
    ram_en    = 1'b0;
    host_gnt  = 1'b0;
    cpu_stall = 1'b0;
    if (host_owns) begin
      ram_ad  = host_ad;
      ram_din = host_din;
    end
    if (rst_n) begin
      if (host_owns) begin
        ram_en    = host_we;
        host_gnt  = 1'b1;
        cpu_stall = cpu_req;
      end else begin
        ram_en = cpu_req & cpu_we;
      end
    end
  end

  // HOST always yields after one cycle, so the CPU loses at most one cycle per access.
  always_comb begin
    next_state = IDLE;
    next_cnt   = '0;
    if (!host_owns && host_req) begin
      if (!cpu_req || cnt == CW'(MAXWAIT - 1)) begin
        next_state = HOST;
      end else begin
        next_state = WAIT;
        next_cnt   = cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      host_dout  <= '0;
      host_valid <= 1'b0;
    end else begin
      state      <= next_state;
      cnt        <= next_cnt;
      host_valid <= host_owns;
      if (host_owns) begin
        host_dout <= ram_dout;
      end
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: reset, CPU access, uncontended and contended
// host access, back-to-back host requests and reset during a HOST cycle.
module tb_ram_arbiter;

  localparam int N = 6;
  localparam int W = 16;
  localparam int MAXWAIT = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cpu_req, cpu_we;
  logic [N-1:0] cpu_ad;
  logic [W-1:0] cpu_din, cpu_dout;
  logic         cpu_stall;
  logic         host_req, host_we;
  logic [N-1:0] host_ad;
  logic [W-1:0] host_din;
  logic         host_gnt;
  logic [W-1:0] host_dout;
  logic         host_valid;
  logic [N-1:0] ram_ad;
  logic [W-1:0] ram_din;
  logic         ram_en;
  logic [W-1:0] ram_dout;
  logic [1:0]   dbg_state;

  logic [W-1:0] mem [0:(1<<N)-1];
  logic         mem_clear;
  logic [W-1:0] exp_q[$];
  int           checks = 0;
  int           failures = 0;

  ram_arbiter #(.N(N), .W(W), .MAXWAIT(MAXWAIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_ad(cpu_ad), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .cpu_stall(cpu_stall),
    .host_req(host_req), .host_we(host_we), .host_ad(host_ad), .host_din(host_din),
    .host_gnt(host_gnt), .host_dout(host_dout), .host_valid(host_valid),
    .ram_ad(ram_ad), .ram_din(ram_din), .ram_en(ram_en), .ram_dout(ram_dout),
    .dbg_state(dbg_state)
  );

  // Clock and reset-time RAM model: synchronous write, combinational read.
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < (1 << N); i++) mem[i] <= '0;
    end else if (ram_en) begin
      mem[ram_ad] <= ram_din;
    end
  end
  assign ram_dout = mem[ram_ad];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic cpu_drive(input logic req, input logic we, input logic [N-1:0] ad,
                           input logic [W-1:0] din);
    cpu_req = req; cpu_we = we; cpu_ad = ad; cpu_din = din;
  endtask

  task automatic host_drive(input logic req, input logic we, input logic [N-1:0] ad,
                            input logic [W-1:0] din);
    host_req = req; host_we = we; host_ad = ad; host_din = din;
  endtask

  task automatic check_host_read(input string tag);
    logic [W-1:0] exp;
    check({tag, "_valid"}, 32'(host_valid), 32'd1);
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 32'(exp_q.size()), 32'd1);
    end else begin
      exp = exp_q.pop_front();
      check({tag, "_dout"}, 32'(host_dout), 32'(exp));
    end
  endtask

  initial begin
    // Reset with a pending host write: nothing may be granted or written.
    rst_n = 1'b0;
    mem_clear = 1'b1;
    cpu_drive(1'b0, 1'b0, '0, '0);
    host_drive(1'b1, 1'b1, 6'd9, 16'hFFFF);
    settle();
    check("rst_gnt0", 32'(host_gnt), 32'd0);
    check("rst_en0", 32'(ram_en), 32'd0);
    tick();
    mem_clear = 1'b0;
    check("rst_gnt1", 32'(host_gnt), 32'd0);
    check("rst_en1", 32'(ram_en), 32'd0);
    tick();
    check("rst_valid", 32'(host_valid), 32'd0);
    check("rst_dout", 32'(host_dout), 32'h0000);
    check("rst_state", 32'(dbg_state), 32'd0);
    check("rst_mem9", 32'(mem[9]), 32'h0000);

    // CPU write then read, no host traffic.
    rst_n = 1'b1;
    host_drive(1'b0, 1'b0, '0, '0);
    cpu_drive(1'b1, 1'b1, 6'd5, 16'h1234);
    settle();
    check("cpu_wr_en", 32'(ram_en), 32'd1);
    check("cpu_wr_stall", 32'(cpu_stall), 32'd0);
    tick();
    cpu_drive(1'b1, 1'b0, 6'd5, 16'h0000);
    settle();
    check("cpu_rd_en", 32'(ram_en), 32'd0);
    check("cpu_rd_dout", 32'(cpu_dout), 32'h1234);
    tick();

    // Uncontended host read of address 5.
    cpu_drive(1'b0, 1'b0, 6'd0, 16'h0000);
    host_drive(1'b1, 1'b0, 6'd5, 16'h0000);
    exp_q.push_back(16'h1234);
    settle();
    check("hrd_t_gnt", 32'(host_gnt), 32'd0);
    tick();
    settle();
    check("hrd_t1_gnt", 32'(host_gnt), 32'd1);
    check("hrd_t1_ad", 32'(ram_ad), 32'd5);
    check("hrd_t1_en", 32'(ram_en), 32'd0);
    tick();
    host_drive(1'b0, 1'b0, 6'd0, 16'h0000);
    settle();
    check("hrd_t2_gnt", 32'(host_gnt), 32'd0);
    check_host_read("hrd_t2");
    tick();
    settle();
    check("hrd_t3_valid", 32'(host_valid), 32'd0);
    check("hrd_t3_hold", 32'(host_dout), 32'h1234);

    // Contended host write of 0xBEEF to address 9 under a held CPU read.
    cpu_drive(1'b1, 1'b0, 6'd5, 16'h0000);
    host_drive(1'b1, 1'b1, 6'd9, 16'hBEEF);
    exp_q.push_back(16'h0000);
    for (int k = 0; k < MAXWAIT; k++) begin
      settle();
      check($sformatf("cont_t%0d_gnt", k), 32'(host_gnt), 32'd0);
      check($sformatf("cont_t%0d_stall", k), 32'(cpu_stall), 32'd0);
      check($sformatf("cont_t%0d_ad", k), 32'(ram_ad), 32'd5);
      check($sformatf("cont_t%0d_cpu", k), 32'(cpu_dout), 32'h1234);
      tick();
    end
    settle();
    check("cont_t4_gnt", 32'(host_gnt), 32'd1);
    check("cont_t4_stall", 32'(cpu_stall), 32'd1);
    check("cont_t4_en", 32'(ram_en), 32'd1);
    check("cont_t4_ad", 32'(ram_ad), 32'd9);
    check("cont_t4_din", 32'(ram_din), 32'hBEEF);
    tick();
    host_drive(1'b0, 1'b0, 6'd0, 16'h0000);
    cpu_drive(1'b1, 1'b0, 6'd9, 16'h0000);
    settle();
    check("cont_t5_gnt", 32'(host_gnt), 32'd0);
    check("cont_t5_stall", 32'(cpu_stall), 32'd0);
    check_host_read("cont_t5");
    check("cont_t5_cpu9", 32'(cpu_dout), 32'hBEEF);
    tick();

    // Host request held continuously with CPU idle: grant every other cycle.
    cpu_drive(1'b0, 1'b0, 6'd0, 16'h0000);
    host_drive(1'b1, 1'b0, 6'd9, 16'h0000);
    tick();
    settle();
    check("b2b_gnt_a", 32'(host_gnt), 32'd1);
    tick();
    settle();
    check("b2b_gap", 32'(host_gnt), 32'd0);
    check("b2b_gap_valid", 32'(host_valid), 32'd1);
    check("b2b_gap_dout", 32'(host_dout), 32'hBEEF);
    tick();
    settle();
    check("b2b_gnt_b", 32'(host_gnt), 32'd1);
    tick();
    host_drive(1'b0, 1'b0, 6'd0, 16'h0000);
    tick();

    // Reset landing on a HOST write cycle: write suppressed, grant dropped.
    host_drive(1'b1, 1'b1, 6'd9, 16'hDEAD);
    tick();
    cpu_drive(1'b1, 1'b0, 6'd9, 16'h0000);
    rst_n = 1'b0;
    settle();
    check("rhost_state", 32'(dbg_state), 32'd2);
    check("rhost_en", 32'(ram_en), 32'd0);
    check("rhost_gnt", 32'(host_gnt), 32'd0);
    check("rhost_stall", 32'(cpu_stall), 32'd0);
    tick();
    rst_n = 1'b1;
    host_drive(1'b0, 1'b0, 6'd0, 16'h0000);
    settle();
    check("rhost_next_state", 32'(dbg_state), 32'd0);
    check("rhost_mem9", 32'(mem[9]), 32'hBEEF);
    check("rhost_cpu9", 32'(cpu_dout), 32'hBEEF);
    check("rhost_valid", 32'(host_valid), 32'd0);
    check("rhost_dout", 32'(host_dout), 32'h0000);
    tick();

    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
